// File: rtl/sram_ctrl_pkg.sv
// Shared types for the serial-write / parallel-read SRAM sequencer.
package sram_ctrl_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    WRITE,
    READ,
    RESP
  } sram_ctrl_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/sram_ctrl_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the requester with priority
// and moves to the other requester after every grant.
module sram_ctrl_rr_arb
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = '0;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      gnt[~ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr <= 1'b0;
    end else if (advance && (|gnt)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Two-requester sequencer for the serial-write / parallel-read SRAM macro.
// Optional read watchdog enabled by defining SRAM_CTRL_TIMEOUT_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int ROWS        = 16,
  parameter  int COLS        = 8,
  parameter  int TIMEOUT_CYC = 15,
  localparam int AW          = $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*COLS-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [COLS-1:0]         rsp_rdata,
  output logic                    rsp_err,
  output logic [AW-1:0]           sram_addr,
  output logic                    sram_serial_in,
  output logic                    sram_shift,
  output logic                    sram_load,
  output logic                    sram_w_en,
  output logic                    sram_r_en,
  input  logic                    sram_data_valid,
  input  logic [COLS-1:0]         sram_data_out
);

  localparam int              BW       = $clog2(COLS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(COLS - 1);
  localparam logic [AW:0]     ROWS_W   = (AW + 1)'(ROWS);

  sram_ctrl_state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_id;
  logic               advance;
  op_e                sel_op;
  logic [AW-1:0]      sel_addr;
  logic [COLS-1:0]    sel_wdata;
  logic               addr_ok;

  logic               id_q;
  logic [AW-1:0]      addr_q;
  logic [COLS-1:0]    wdata_q;
  logic [COLS-1:0]    rdata_q;
  logic               err_q;
  logic [BW-1:0]      bit_cnt;
  logic               tmo_last;

  assign advance   = (state_q == IDLE) && (|req_valid);
  assign gnt_id    = gnt[1];
  assign sel_op    = (gnt_id ? req_we[1] : req_we[0]) ? OP_WRITE : OP_READ;
  assign sel_addr  = gnt_id ? req_addr[AW +: AW] : req_addr[0 +: AW];
  assign sel_wdata = gnt_id ? req_wdata[COLS +: COLS] : req_wdata[0 +: COLS];
  assign addr_ok   = {1'b0, sel_addr} < ROWS_W;

  sram_ctrl_rr_arb u_arb (
    .clk     (clk),
    .arst_n  (arst_n),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

`ifdef SRAM_CTRL_TIMEOUT_EN
  localparam int             TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_last = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == READ) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign tmo_last = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    req_ready      = '0;
    rsp_valid      = 1'b0;
    rsp_id         = 1'b0;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;
    sram_addr      = '0;
    sram_serial_in = 1'b0;
    sram_shift     = 1'b0;
    sram_load      = 1'b0;
    sram_w_en      = 1'b0;
    sram_r_en      = 1'b0;

    if (state_q != IDLE) begin
      sram_addr = addr_q;
    end

    case (state_q)
      IDLE: begin
        req_ready = gnt;
        if (|gnt) begin
          if (!addr_ok)                state_d = RESP;
          else if (sel_op == OP_WRITE) state_d = SHIFT;
          else                         state_d = READ;
        end
      end
      SHIFT: begin
        sram_shift     = 1'b1;
        sram_serial_in = wdata_q[COLS-1];
        if (bit_cnt == LAST_BIT) state_d = LOAD;
      end
      LOAD: begin
        sram_load = 1'b1;
        state_d   = WRITE;
      end
      WRITE: begin
        sram_w_en = 1'b1;
        state_d   = RESP;
      end
      READ: begin
        sram_r_en = 1'b1;
        if (sram_data_valid || tmo_last) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            id_q    <= gnt_id;
            // Rejected addresses never reach the macro, not even on sram_addr.
            addr_q  <= addr_ok ? sel_addr : '0;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            err_q   <= !addr_ok;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          wdata_q <= wdata_q << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        READ: begin
          // Data arriving in the final watchdog cycle takes precedence.
          if (sram_data_valid) rdata_q <= sram_data_out;
          else if (tmo_last)   err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl (ROWS=12 so out-of-range addresses are reachable).
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [1:0]  req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [3:0]  sram_addr;
  logic        sram_serial_in, sram_shift, sram_load, sram_w_en, sram_r_en;
  logic        sram_data_valid;
  logic [7:0]  sram_data_out;

  int n_checks = 0;
  int n_errors = 0;

  logic       model_en  = 1'b1;
  logic       use_addr  = 1'b0;
  logic [7:0] mdl_data  = 8'h00;
  int         rcnt      = 0;

  sram_ctrl #(.ROWS(12), .COLS(8), .TIMEOUT_CYC(15)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .sram_addr       (sram_addr),
    .sram_serial_in  (sram_serial_in),
    .sram_shift      (sram_shift),
    .sram_load       (sram_load),
    .sram_w_en       (sram_w_en),
    .sram_r_en       (sram_r_en),
    .sram_data_valid (sram_data_valid),
    .sram_data_out   (sram_data_out)
  );

  always #5 clk = ~clk;

  // SRAM model: data_valid two cycles after r_en rises.
  always @(negedge clk) begin
    if (sram_r_en && model_en && arst_n) begin
      sram_data_valid = (rcnt == 2);
      sram_data_out   = use_addr ? {4'hC, sram_addr} : mdl_data;
      rcnt            = rcnt + 1;
    end else begin
      sram_data_valid = 1'b0;
      sram_data_out   = 8'h00;
      rcnt            = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {10'b0, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, sram_addr,
            sram_serial_in, sram_shift, sram_load, sram_w_en, sram_r_en};
  endfunction

  function automatic logic [31:0] sram_out();
    return {23'b0, sram_addr, sram_serial_in, sram_shift, sram_load, sram_w_en, sram_r_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int id, input logic [3:0] a, input logic [7:0] d);
    req_valid          = 2'b00;
    req_valid[id]      = 1'b1;
    req_we[id]         = 1'b1;
    req_addr[id*4 +: 4]  = a;
    req_wdata[id*8 +: 8] = d;
    #1;
    check("wr_ready", 32'(req_ready), 32'(1 << id));
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      check("wr_shift", 32'(sram_shift), 1);
      check("wr_bit", 32'(sram_serial_in), 32'(d[7-i]));
      check("wr_addr", 32'(sram_addr), 32'(a));
      tick();
    end
    check("wr_load", 32'({sram_shift, sram_load, sram_w_en}), 32'b010);
    tick();
    check("wr_wen", 32'({sram_load, sram_w_en}), 32'b01);
    check("wr_wen_addr", 32'(sram_addr), 32'(a));
    tick();
    check("wr_rsp", 32'({rsp_valid, rsp_id, rsp_err}), 32'({1'b1, id[0], 1'b0}));
    check("wr_rdata", 32'(rsp_rdata), 0);
    tick();
    check("wr_after", 32'({rsp_valid, sram_addr}), 0);
  endtask

  initial begin
    int lat, ren, n;
    logic saw;

    arst_n    = 1'b0;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    sram_data_valid = 1'b0;
    sram_data_out   = 8'h00;
    tick();
    tick();
    check("reset_outs", all_out(), 0);
    arst_n = 1'b1;
    tick();
    check("idle_outs", all_out(), 0);

    // Write A5 to addr 3 from requester 0.
    do_write(0, 4'd3, 8'hA5);

    // Read addr 3 from requester 1.
    mdl_data  = 8'hA5;
    use_addr  = 1'b0;
    req_valid = 2'b10;
    req_we    = 2'b00;
    req_addr  = {4'd3, 4'd0};
    #1;
    check("rd_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b00;
    lat = 1;
    ren = 0;
    for (int i = 0; i < 50; i++) begin
      if (sram_r_en) ren++;
      if (rsp_valid) break;
      tick();
      lat++;
    end
    check("rd_ren_cycles", ren, 3);
    check("rd_latency", lat, 4);
    check("rd_rsp", 32'({rsp_valid, rsp_id, rsp_err}), 32'b110);
    check("rd_rdata", 32'(rsp_rdata), 32'hA5);
    tick();

    // Both requesters valid continuously: grants alternate.
    use_addr  = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = {4'd2, 4'd1};
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        check("alt_id", 32'(rsp_id), n % 2);
        check("alt_rdata", 32'(rsp_rdata), (n % 2) ? 32'hC2 : 32'hC1);
        n++;
        if (n == 4) req_valid = 2'b00;
      end
      if (n == 4) break;
      tick();
    end
    check("alt_count", n, 4);
    tick();
    use_addr = 1'b0;

    // Out-of-range read (addr 12 with 12 rows).
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = {4'd0, 4'd12};
    #1;
    check("oor_ready", 32'(req_ready), 32'b01);
    check("oor_accept_sram", sram_out(), 0);
    tick();
    req_valid = 2'b00;
    check("oor_rsp", 32'({rsp_valid, rsp_id, rsp_err}), 32'b101);
    check("oor_rdata", 32'(rsp_rdata), 0);
    check("oor_sram", sram_out(), 0);
    tick();

    // Highest legal address from requester 1.
    do_write(1, 4'd11, 8'h3C);

    // Read with no data_valid from the SRAM.
    model_en  = 1'b0;
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = {4'd0, 4'd5};
    #1;
    tick();
    req_valid = 2'b00;
`ifdef SRAM_CTRL_TIMEOUT_EN
    lat = 1;
    ren = 0;
    for (int i = 0; i < 100; i++) begin
      if (sram_r_en) ren++;
      if (rsp_valid) break;
      tick();
      lat++;
    end
    check("tmo_ren_cycles", ren, 15);
    check("tmo_latency", lat, 16);
    check("tmo_rsp", 32'({rsp_valid, rsp_id, rsp_err}), 32'b101);
    check("tmo_rdata", 32'(rsp_rdata), 0);
    tick();
`else
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) saw = 1'b1;
      tick();
    end
    check("notmo_ren", 32'(sram_r_en), 1);
    check("notmo_no_rsp", 32'(saw), 0);
    arst_n = 1'b0;
    #1;
    check("notmo_reset_outs", all_out(), 0);
    tick();
    arst_n = 1'b1;
    tick();
`endif
    model_en = 1'b1;

    // Reset during the fourth shift cycle.
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {4'd0, 4'd7};
    req_wdata = {8'h00, 8'hFF};
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    check("rst_in_shift", 32'(sram_shift), 1);
    arst_n = 1'b0;
    #1;
    check("rst_outs", all_out(), 0);
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid) saw = 1'b1;
    end
    arst_n = 1'b1;
    tick();
    if (rsp_valid) saw = 1'b1;
    check("rst_no_rsp", 32'(saw), 0);
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = {4'd12, 4'd12};
    #1;
    check("rst_grant0", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_err}), 32'b101);
    tick();
    check("rst_final_idle", all_out(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Two-requester sequencer for the serial-write / parallel-read SRAM macro.
- Round-robin arbitrates the word-level read/write requests.
- Serializes write data into the macro's shift register MSB-first, then pulses load and w_en.
- Issues r_en for reads and returns one response per accepted request.

Parameters:
- ROWS, 16, number of SRAM words; address width AW = $clog2(ROWS).
- COLS, 8, word width in bits; equals the number of shift cycles per write.
- TIMEOUT_CYC, 15, read watchdog limit in cycles; used only with SRAM_CTRL_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- arst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  request valid, one bit per requester.
- req_ready  output  2  one-cycle accept strobe per requester.
- req_we  input  2  1 = write, 0 = read, per requester.
- req_addr  input  2*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  input  2*COLS  packed write data; requester i at [i*COLS +: COLS].
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_id  output  1  requester index of the response.
- rsp_rdata  output  COLS  read data; 0 for write responses and errors.
- rsp_err  output  1  address out of range or read timeout.
- sram_addr  output  AW  SRAM address, held stable for the whole operation.
- sram_serial_in  output  1  serial write bit.
- sram_shift  output  1  shift enable.
- sram_load  output  1  load shift register into the parallel latch.
- sram_w_en  output  1  write strobe.
- sram_r_en  output  1  read enable.
- sram_data_valid  input  1  read data valid from the SRAM.
- sram_data_out  input  COLS  read data from the SRAM.
- Clock and reset: clk, reset arst_n (asynchronous, active-low).

Behaviour:
- Reset: all outputs 0; FSM to IDLE; round-robin pointer to requester 0.
- Reset mid-operation aborts the operation and emits no response.
- FSM states: IDLE, SHIFT, LOAD, WRITE, READ, RESP.
- IDLE: if any req_valid, grant by round-robin (priority to the requester not granted last).
  - Assert req_ready[g] that cycle and latch we/addr/wdata.
  - Pointer toggles to the other requester after every grant.
  - addr >= ROWS: go to RESP with rsp_err=1 and no SRAM activity.
  - Write: go to SHIFT. Read: go to READ.
- SHIFT: sram_shift=1 for exactly COLS cycles; sram_serial_in = wdata bit COLS-1 first, down to bit 0. Bit counter counts 0..COLS-1, then go to LOAD.
- LOAD: sram_load=1 for 1 cycle, then WRITE.
- WRITE: sram_w_en=1 for 1 cycle, then RESP.
- READ: sram_r_en held high until sram_data_valid=1.
  - In the cycle data_valid is high, capture sram_data_out, deassert r_en next cycle, go to RESP.
- RESP: rsp_valid=1 for 1 cycle with rsp_id, rsp_rdata, rsp_err; then IDLE.
- Latency, accept at cycle 0:
  - Write: rsp_valid at cycle COLS+3.
  - Read: rsp_valid one cycle after data_valid.
  - Out-of-range: rsp_valid at cycle 1.
- Throughput: no new accept before the RESP-to-IDLE transition; accepts are at least COLS+4 cycles apart for writes.
- Only one sram_* strobe may be active per cycle. sram_addr is held from accept through RESP and is 0 in IDLE.
- A requester dropping req_valid before its grant is legal and is not latched.

Optional Feature:
- Macro SRAM_CTRL_TIMEOUT_EN.
- Defined: a counter runs in READ. If data_valid is not seen within TIMEOUT_CYC cycles (count reaches TIMEOUT_CYC-1), drop r_en and go to RESP with rsp_err=1, rsp_rdata=0. A data_valid arriving in that same final cycle wins: normal data, err=0.
- Undefined: READ waits indefinitely; rsp_err is set only for out-of-range addresses.

Decomposition:
- Package sram_ctrl_pkg:
  - State enum sram_ctrl_state_e.
  - Op enum (OP_READ, OP_WRITE).
  - Constant NUM_REQ = 2.
- Sub-module sram_ctrl_rr_arb: 2-way round-robin grant with a pointer register. Inputs: req, advance. Output: one-hot gnt.

Test Plan:
- Req0 write addr=3 wdata=8'hA5 -> serial_in sequence 1,0,1,0,0,1,0,1 over 8 shift cycles; load at cycle 9; w_en with sram_addr=3 at cycle 10; rsp_valid cycle 11 with id=0, err=0.
- Req1 read addr=3, model returns data_valid 2 cycles after r_en with 8'hA5 -> r_en high 3 cycles; rsp_rdata=8'hA5, id=1.
- Both requesters valid continuously, pointer at 0 -> grants alternate 0,1,0,1 across four operations.
- Read addr=16 with ROWS=16 reconfigured as ROWS=12, addr=12 -> no sram_* activity; rsp_valid at cycle 1 with err=1, rdata=0.
- SRAM_CTRL_TIMEOUT_EN defined, read with no data_valid -> r_en drops after 15 cycles; rsp_err=1. Undefined -> r_en still high after 100 cycles.
- arst_n asserted during SHIFT cycle 4 -> all outputs 0 immediately; no rsp_valid; next request served from requester 0 priority.
